stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Button-driven stopwatch controller for the lab board. It takes two single-cycle push-button pulses, produced upstream by one-shot pulse generators, and sequences a BCD time counter in MM:SS.d format with start/pause, lap-freeze and clear functions. It presents the five BCD digits to the seven-segment display driver.

## Interface
- TICK_DIV, 5_000_000: clk cycles per 0.1 s tick (50 MHz board); legal range ≥ 2.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- start_p  in  1  one-cycle pulse: start/pause toggle
- lap_p  in  1  one-cycle pulse: lap/resume when counting, clear when paused
- min_t  out  4  BCD tens of minutes (0–5)
- min_u  out  4  BCD minutes units (0–9)
- sec_t  out  4  BCD tens of seconds (0–5)
- sec_u  out  4  BCD seconds units (0–9)
- dsec  out  4  BCD tenths of seconds (0–9)
- running  out  1  high while state is RUN or LAP
- lap_hold  out  1  high while state is LAP (display frozen)
- tick  out  1  one-cycle pulse on each count increment

Reset is synchronous and active-high: rst sampled high on a clk edge resets the block.

## Operation
- Internal registers:
  - live count: five BCD digits.
  - lap snapshot: five BCD digits.
  - prescaler: width clog2(TICK_DIV), counts 0..TICK_DIV-1.
  - state: 2-bit FSM.
- Inputs are acted on in every cycle they are high. There is no internal edge detection, because upstream guarantees single-cycle pulses.
- Same-cycle start_p and lap_p: start_p wins and lap_p is dropped.
- FSM states and transitions:
  - IDLE: count, snapshot and prescaler are all 0.
    - start_p → RUN.
    - lap_p → ignored.
  - RUN: the prescaler advances.
    - start_p → PAUSE.
    - lap_p → LAP; the snapshot captures the live count on that edge.
  - LAP: counting continues; the display shows the snapshot.
    - lap_p → RUN (display returns to live).
    - start_p → PAUSE (display returns to live).
  - PAUSE: the prescaler and count hold.
    - start_p → RUN; the prescaler resumes from its held value.
    - lap_p → IDLE; count, snapshot and prescaler clear.
- Prescaler in RUN and LAP: increments each cycle. At value TICK_DIV-1 it wraps to 0, and the live count increments on the same edge.
- BCD increment rules, applied in one cycle as a ripple:
  - dsec 9→0 carries into sec_u.
  - sec_u 9→0 carries into sec_t.
  - sec_t 5→0 carries into min_u.
  - min_u 9→0 carries into min_t.
  - min_t 5→0: rollover; 59:59.9 wraps to 00:00.0 and counting continues.
- Digits never take non-BCD values or values above their stated maximum.

## Timing
- Reset: state = IDLE; count, snapshot and prescaler = 0; all digit outputs = 0; running = lap_hold = tick = 0.
- rst has priority over start_p and lap_p in the same cycle.
- A reset asserted mid-RUN or mid-LAP clears everything on that edge.
- State change: occurs on the edge where the pulse is sampled. running and lap_hold are decoded from the state register, so they change on that same edge.
- First increment: start_p sampled at edge k in IDLE → live count increments at edge k+TICK_DIV.
- After that, increments occur every TICK_DIV cycles while in RUN or LAP.
- tick is a registered pulse, high for the one cycle following each increment edge.
- Digit outputs are registered from a mux of (lap_hold ? snapshot : live), giving one cycle of latency after a count or state change.
  - Example: an increment at edge n is visible on the outputs after edge n+1.
- PAUSE→RUN: the prescaler does not reset. Total elapsed cycles across pauses are preserved exactly.
- Entering LAP when lap_p coincides with an increment edge: the snapshot captures the pre-increment value.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset then idle: rst for 2 cycles, then 20 idle cycles → all digits 0, running = 0, tick never high, and lap_p pulses have no effect.
- Start/count: start_p at edge 0 → tick after edges 4, 8, 12, … ; dsec = 1 visible after edge 5; after 40 ticks, sec_t = 0, sec_u = 4, dsec = 0.
- Pause/resume preservation: start, pause after 6 cycles (prescaler = 2, dsec = 1), hold 50 cycles with no change, resume → next increment exactly 2 cycles after the resume edge.
- Lap freeze: lap_p at dsec = 3 → lap_hold = 1 and the display stays 00:00.3 while ticks continue. A second lap_p after 10 more ticks → display shows 00:01.3.
- Rollover and clear: preload by running 35999 ticks → display 59:59.9; the next tick → 00:00.0 with running = 1. Then start_p followed by lap_p → IDLE with all zeros.
- Priority: start_p and lap_p high in the same cycle in RUN → PAUSE, no snapshot taken. rst together with start_p in IDLE → remains IDLE.

Source files
------------

// File: rtl/stopwatch_if.sv
`default_nettype none
// ------------------------------------------------------------------
// stopwatch_if : button pulses in, BCD digits and status flags out
// Rev 1.0
// ------------------------------------------------------------------
interface stopwatch_if;
   logic       start_p;
   logic       lap_p;
   logic [3:0] min_t;
   logic [3:0] min_u;
   logic [3:0] sec_t;
   logic [3:0] sec_u;
   logic [3:0] dsec;
   logic       running;
   logic       lap_hold;
   logic       tick;

   modport master (
      output start_p, lap_p,
      input  min_t, min_u, sec_t, sec_u, dsec, running, lap_hold, tick
   );

   modport slave (
      input  start_p, lap_p,
      output min_t, min_u, sec_t, sec_u, dsec, running, lap_hold, tick
   );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// stopwatch_ctrl : MM:SS.d BCD stopwatch with start/pause, lap and clear
// Rev 1.0
// ------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter int TICK_DIV = 5_000_000
) (
   input  logic        clk,
   input  logic        rst,
   stopwatch_if.slave  sw
);
   localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      LAP   = 2'd2,
      PAUSE = 2'd3
   } state_t;

   // digit order: [4]=min_t [3]=min_u [2]=sec_t [1]=sec_u [0]=dsec
   typedef logic [4:0][3:0] bcd_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   bcd_t          live_q, live_d;
   bcd_t          snap_q, snap_d;
   bcd_t          disp_q, disp_d;
   logic          tick_q;
   logic          counting;
   logic          inc;

   function automatic bcd_t bcd_inc(input bcd_t v);
      bcd_t       r;
      logic       carry;
      logic [3:0] lim;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 5; i++) begin
         lim = (i == 2 || i == 4) ? 4'd5 : 4'd9;
         if (carry) begin
            if (v[i] >= lim) begin
               r[i] = 4'd0;
            end else begin
               r[i]  = v[i] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign counting = (state_q == RUN) || (state_q == LAP);
   assign inc      = counting && (presc_q == PRE_MAX);

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      live_d  = live_q;
      snap_d  = snap_q;

      if (counting) begin
         presc_d = inc ? '0 : presc_q + PW'(1);
         if (inc) begin
            live_d = bcd_inc(live_q);
         end
      end

      // start_p outranks lap_p in every state
      case (state_q)
         IDLE: begin
            if (sw.start_p) state_d = RUN;
         end
         RUN: begin
            if (sw.start_p) begin
               state_d = PAUSE;
            end else if (sw.lap_p) begin
               state_d = LAP;
               snap_d  = live_q;
            end
         end
         LAP: begin
            if (sw.start_p)    state_d = PAUSE;
            else if (sw.lap_p) state_d = RUN;
         end
         PAUSE: begin
            if (sw.start_p) begin
               state_d = RUN;
            end else if (sw.lap_p) begin
               state_d = IDLE;
               presc_d = '0;
               live_d  = '0;
               snap_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      disp_d = (state_q == LAP) ? snap_q : live_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         presc_q <= '0;
         live_q  <= '0;
         snap_q  <= '0;
         disp_q  <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         live_q  <= live_d;
         snap_q  <= snap_d;
         disp_q  <= disp_d;
         tick_q  <= inc;
      end
   end

   assign sw.min_t    = disp_q[4];
   assign sw.min_u    = disp_q[3];
   assign sw.sec_t    = disp_q[2];
   assign sw.sec_u    = disp_q[1];
   assign sw.dsec     = disp_q[0];
   assign sw.running  = counting;
   assign sw.lap_hold = (state_q == LAP);
   assign sw.tick     = tick_q;
endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_stopwatch_ctrl : vector table, directed sequences, random vs model
// Rev 1.0
// ------------------------------------------------------------------
module tb_stopwatch_ctrl;
   localparam int TD      = 4;
   localparam int TD_ROLL = 2;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic rst_r = 1'b1;
   always #5 clk = ~clk;

   stopwatch_if sw_m ();
   stopwatch_if sw_r ();

   stopwatch_ctrl #(.TICK_DIV(TD))      dut      (.clk(clk), .rst(rst),   .sw(sw_m));
   stopwatch_ctrl #(.TICK_DIV(TD_ROLL)) dut_roll (.clk(clk), .rst(rst_r), .sw(sw_r));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        s;
      logic        l;
      logic        r;
      logic [19:0] disp;
      logic        run;
      logic        hold;
      logic        tick;
   } vec_t;
   vec_t tbl [21];

   // reference model: elapsed tenths as a plain integer, states 0 idle 1 run 2 lap 3 pause
   int          m_state = 0;
   int          m_count = 0;
   int          m_snap  = 0;
   int          m_cyc   = 0;
   logic [19:0] e_disp  = '0;
   logic        e_tick  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [19:0] to_bcd(input int t);
      int mins;
      int secs;
      mins = t / 600;
      secs = (t / 10) % 60;
      return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), 4'(t % 10)};
   endfunction

   function automatic logic [19:0] disp_m();
      return {sw_m.min_t, sw_m.min_u, sw_m.sec_t, sw_m.sec_u, sw_m.dsec};
   endfunction

   function automatic logic [19:0] disp_r();
      return {sw_r.min_t, sw_r.min_u, sw_r.sec_t, sw_r.sec_u, sw_r.dsec};
   endfunction

   task automatic model_update(input logic s, input logic l, input logic r);
      bit run_old;
      bit inc;
      int old_count;
      if (r) begin
         m_state = 0; m_count = 0; m_snap = 0; m_cyc = 0;
         e_disp  = '0; e_tick = 1'b0;
      end else begin
         run_old   = (m_state == 1) || (m_state == 2);
         old_count = m_count;
         e_disp    = (m_state == 2) ? to_bcd(m_snap) : to_bcd(m_count);
         inc       = run_old && (((m_cyc + 1) % TD) == 0);
         e_tick    = inc;
         if (run_old) begin
            m_cyc = (m_cyc + 1) % TD;
            if (inc) m_count = (m_count + 1) % 36000;
         end
         if (s) begin
            m_state = (m_state == 0 || m_state == 3) ? 1 : 3;
         end else if (l) begin
            if (m_state == 1) begin
               m_state = 2;
               m_snap  = old_count;
            end else if (m_state == 2) begin
               m_state = 1;
            end else if (m_state == 3) begin
               m_state = 0; m_count = 0; m_snap = 0; m_cyc = 0;
            end
         end
      end
   endtask

   task automatic step(input logic s, input logic l, input logic r);
      sw_m.start_p = s;
      sw_m.lap_p   = l;
      rst          = r;
      @(posedge clk);
      model_update(s, l, r);
      #1;
      sw_m.start_p = 1'b0;
      sw_m.lap_p   = 1'b0;
      rst          = 1'b0;
   endtask

   task automatic check_model();
      check("model_disp",     32'(disp_m()),    32'(e_disp));
      check("model_running",  32'(sw_m.running),  32'(m_state == 1 || m_state == 2));
      check("model_lap_hold", 32'(sw_m.lap_hold), 32'(m_state == 2));
      check("model_tick",     32'(sw_m.tick),     32'(e_tick));
   endtask

   function automatic vec_t mk(input logic s, input logic l, input logic r, input logic [19:0] d,
                               input logic run, input logic hold, input logic tk);
      vec_t v;
      v.s = s; v.l = l; v.r = r; v.disp = d; v.run = run; v.hold = hold; v.tick = tk;
      return v;
   endfunction

   initial begin
      int   tick_seen;
      int   tick_cnt;
      logic s;
      logic l;
      logic r;

      sw_m.start_p = 1'b0;
      sw_m.lap_p   = 1'b0;
      sw_r.start_p = 1'b0;
      sw_r.lap_p   = 1'b0;

      //          s     l     r     disp     run   hold  tick
      tbl[0]  = mk(1'b0, 1'b0, 1'b1, 20'h0, 1'b0, 1'b0, 1'b0);
      tbl[1]  = mk(1'b0, 1'b0, 1'b1, 20'h0, 1'b0, 1'b0, 1'b0);
      tbl[2]  = mk(1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
      tbl[3]  = mk(1'b1, 1'b0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
      tbl[4]  = mk(1'b0, 1'b0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
      tbl[5]  = mk(1'b0, 1'b0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
      tbl[6]  = mk(1'b0, 1'b0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
      tbl[7]  = mk(1'b0, 1'b0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b1);
      tbl[8]  = mk(1'b0, 1'b0, 1'b0, 20'h1, 1'b1, 1'b0, 1'b0);
      tbl[9]  = mk(1'b0, 1'b1, 1'b0, 20'h1, 1'b1, 1'b1, 1'b0);
      tbl[10] = mk(1'b0, 1'b0, 1'b0, 20'h1, 1'b1, 1'b1, 1'b0);
      tbl[11] = mk(1'b0, 1'b0, 1'b0, 20'h1, 1'b1, 1'b1, 1'b1);
      tbl[12] = mk(1'b0, 1'b0, 1'b0, 20'h1, 1'b1, 1'b1, 1'b0);
      tbl[13] = mk(1'b1, 1'b0, 1'b0, 20'h1, 1'b0, 1'b0, 1'b0);
      tbl[14] = mk(1'b0, 1'b0, 1'b0, 20'h2, 1'b0, 1'b0, 1'b0);
      tbl[15] = mk(1'b0, 1'b1, 1'b0, 20'h2, 1'b0, 1'b0, 1'b0);
      tbl[16] = mk(1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
      tbl[17] = mk(1'b1, 1'b1, 1'b0, 20'h0, 1'b1, 1'b0, 1'b0);
      tbl[18] = mk(1'b1, 1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
      tbl[19] = mk(1'b1, 1'b0, 1'b1, 20'h0, 1'b0, 1'b0, 1'b0);
      tbl[20] = mk(1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 21; i++) begin
         step(tbl[i].s, tbl[i].l, tbl[i].r);
         check($sformatf("vec%0d_disp", i),     32'(disp_m()),      32'(tbl[i].disp));
         check($sformatf("vec%0d_running", i),  32'(sw_m.running),  32'(tbl[i].run));
         check($sformatf("vec%0d_lap_hold", i), 32'(sw_m.lap_hold), 32'(tbl[i].hold));
         check($sformatf("vec%0d_tick", i),     32'(sw_m.tick),     32'(tbl[i].tick));
      end

      // idle with stray lap pulses
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, (i % 5) == 2, 1'b0);
         check("idle_disp", 32'(disp_m()),     32'h0);
         check("idle_run",  32'(sw_m.running), 32'h0);
         check("idle_tick", 32'(sw_m.tick),    32'h0);
      end

      // 40 ticks from start
      step(1'b1, 1'b0, 1'b0);
      repeat (161) step(1'b0, 1'b0, 1'b0);
      check("count40_disp", 32'(disp_m()), 32'h00040);
      check_model();

      // pause keeps the partial prescaler phase
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("pause_disp", 32'(disp_m()),     32'h1);
      check("pause_run",  32'(sw_m.running), 32'h0);
      tick_seen = 0;
      for (int i = 0; i < 50; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (sw_m.tick) tick_seen++;
      end
      check("pause_hold_disp", 32'(disp_m()), 32'h1);
      check("pause_no_tick",   32'(tick_seen), 32'h0);
      step(1'b1, 1'b0, 1'b0);
      check("resume_run", 32'(sw_m.running), 32'h1);
      step(1'b0, 1'b0, 1'b0);
      check("resume_early_tick", 32'(sw_m.tick), 32'h0);
      step(1'b0, 1'b0, 1'b0);
      check("resume_tick", 32'(sw_m.tick), 32'h1);
      step(1'b0, 1'b0, 1'b0);
      check("resume_disp", 32'(disp_m()), 32'h2);

      // lap freeze while counting continues
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      repeat (12) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("lap_hold_set", 32'(sw_m.lap_hold), 32'h1);
      tick_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (sw_m.tick) tick_cnt++;
      end
      check("lap_frozen_disp", 32'(disp_m()),  32'h00003);
      check("lap_ticks",       32'(tick_cnt),  32'd10);
      step(1'b0, 1'b1, 1'b0);
      check("lap_release", 32'(sw_m.lap_hold), 32'h0);
      step(1'b0, 1'b0, 1'b0);
      check("lap_live_disp", 32'(disp_m()), 32'h00013);
      check_model();

      // randomized traffic against the model
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 1500; i++) begin
         s = ($urandom_range(0, 15) == 0);
         l = ($urandom_range(0, 11) == 0);
         r = ($urandom_range(0, 299) == 0);
         step(s, l, r);
         check_model();
      end

      // full-range rollover on the fast-divider instance
      rst_r = 1'b1;
      @(posedge clk);
      #1;
      rst_r        = 1'b0;
      sw_r.start_p = 1'b1;
      @(posedge clk);
      #1;
      sw_r.start_p = 1'b0;
      repeat (71999) @(posedge clk);
      #1;
      check("roll_max_disp", 32'(disp_r()), 32'h59599);
      repeat (2) @(posedge clk);
      #1;
      check("roll_wrap_disp", 32'(disp_r()),     32'h0);
      check("roll_wrap_run",  32'(sw_r.running), 32'h1);
      sw_r.start_p = 1'b1;
      @(posedge clk);
      #1;
      sw_r.start_p = 1'b0;
      sw_r.lap_p   = 1'b1;
      @(posedge clk);
      #1;
      sw_r.lap_p = 1'b0;
      @(posedge clk);
      #1;
      check("clear_disp", 32'(disp_r()),     32'h0);
      check("clear_run",  32'(sw_r.running), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
